// File: rtl/vga_pkg.sv
// VGA 640x480@60 timing constants, lock FSM states and a wrap helper.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FPORCH = 16;
  localparam int VGA_H_PULSE  = 96;
  localparam int VGA_H_MAX    = 800;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FPORCH = 10;
  localparam int VGA_V_PULSE  = 2;
  localparam int VGA_V_MAX    = 525;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  function automatic logic [9:0] wrap_inc(
    input logic [9:0] v,
    input logic [9:0] last
  );
    return (v == last) ? 10'd0 : v + 10'd1;
  endfunction

endpackage

// File: rtl/sync_edge_detector.sv
// Two-flop synchronizer with rise/fall strobes; idles high.
module sync_edge_detector (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= sig;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel column/row from VGA sync pulses and tracks lock quality.
module vga_sync_decoder
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FPORCH = VGA_H_FPORCH,
  parameter int H_PULSE  = VGA_H_PULSE,
  parameter int H_MAX    = VGA_H_MAX,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FPORCH = VGA_V_FPORCH,
  parameter int V_PULSE  = VGA_V_PULSE,
  parameter int V_MAX    = VGA_V_MAX
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_VGA_HSync,
  input  logic       i_VGA_VSync,
  input  logic [8:0] i_VGA_Color,
  output logic       o_Locked,
  output logic [9:0] o_Column,
  output logic [9:0] o_Row,
  output logic       o_Pixel_Valid,
  output logic [8:0] o_Color,
  output logic       o_Frame_Start,
  output logic [7:0] o_Error_Count
);

  localparam logic [9:0] H_FALL = 10'(H_ACTIVE + H_FPORCH);
  localparam logic [9:0] H_RISE = 10'(H_ACTIVE + H_FPORCH + H_PULSE);
  localparam logic [9:0] V_FALL = 10'(V_ACTIVE + V_FPORCH);
  localparam logic [9:0] V_RISE = 10'(V_ACTIVE + V_FPORCH + V_PULSE);
  localparam logic [9:0] H_LAST = 10'(H_MAX - 1);
  localparam logic [9:0] V_LAST = 10'(V_MAX - 1);
  localparam int         TW     = $clog2(2 * H_MAX + 1);

  logic          h_rise, h_fall, v_rise, v_fall;
  logic [8:0]    c1, c2, c3;
  logic [9:0]    col, row;
  logic [9:0]    col_inc, row_inc;
  logic [9:0]    col_n, row_n;
  logic [TW-1:0] tmo_cnt;
  logic          tmo, mism, bad;
  logic [7:0]    err_cnt;
  state_t        state;
  logic          valid;

  sync_edge_detector u_hs (
    .clk  (i_Clk),
    .rst  (i_Reset),
    .sig  (i_VGA_HSync),
    .rise (h_rise),
    .fall (h_fall)
  );

  sync_edge_detector u_vs (
    .clk  (i_Clk),
    .rst  (i_Reset),
    .sig  (i_VGA_VSync),
    .rise (v_rise),
    .fall (v_fall)
  );

  // Mismatch checks use the free-running (pre-force) count.
  always_comb begin
    col_inc = wrap_inc(col, H_LAST);
    row_inc = (col == H_LAST) ? wrap_inc(row, V_LAST) : row;
    col_n   = col_inc;
    row_n   = row_inc;
    if (h_fall) col_n = H_FALL;
    if (v_fall) begin
      row_n = V_FALL;
      col_n = '0;
    end
    mism = (h_fall && col_inc != H_FALL)
         | (h_rise && col_inc != H_RISE)
         | (v_fall && (row_inc != V_FALL || col_inc != '0))
         | (v_rise && (row_inc != V_RISE || col_inc != '0));
    tmo  = !h_fall && (tmo_cnt == TW'(2 * H_MAX - 1));
    bad  = mism | tmo;
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      col     <= '0;
      row     <= '0;
      tmo_cnt <= '0;
      c1      <= '0;
      c2      <= '0;
      c3      <= '0;
    end else begin
      col     <= col_n;
      row     <= row_n;
      tmo_cnt <= (h_fall || tmo) ? '0 : tmo_cnt + 1'b1;
      c1      <= i_VGA_Color;
      c2      <= c1;
      c3      <= c2;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state   <= SEARCH;
      err_cnt <= '0;
    end else begin
      unique case (state)
        SEARCH: if (v_fall) state <= ACQUIRE;
        ACQUIRE, LOCKED: begin
          if (bad) begin
            state <= SEARCH;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          end else if (v_fall) begin
            state <= LOCKED;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

  assign valid = (state == LOCKED)
               && (col < 10'(H_ACTIVE))
               && (row < 10'(V_ACTIVE));

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      o_Locked      <= 1'b0;
      o_Column      <= '0;
      o_Row         <= '0;
      o_Pixel_Valid <= 1'b0;
      o_Color       <= '0;
      o_Frame_Start <= 1'b0;
      o_Error_Count <= '0;
    end else begin
      o_Locked      <= (state == LOCKED);
      o_Column      <= col;
      o_Row         <= row;
      o_Pixel_Valid <= valid;
      o_Color       <= valid ? c3 : 9'd0;
      o_Frame_Start <= (state == LOCKED) && col == '0 && row == '0;
      o_Error_Count <= err_cnt;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a shrunken 16x10 raster.
module tb_vga_sync_decoder;

  localparam int H_ACT = 8;
  localparam int H_FP  = 2;
  localparam int H_PW  = 3;
  localparam int H_MX  = 16;
  localparam int V_ACT = 6;
  localparam int V_FP  = 1;
  localparam int V_PW  = 2;
  localparam int V_MX  = 10;
  localparam int HS    = H_ACT + H_FP;
  localparam int VS    = V_ACT + V_FP;
  localparam int FRAME = H_MX * V_MX;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hs  = 1'b1;
  logic       vs  = 1'b1;
  logic [8:0] color = '0;
  logic       o_Locked;
  logic [9:0] o_Column;
  logic [9:0] o_Row;
  logic       o_Pixel_Valid;
  logic [8:0] o_Color;
  logic       o_Frame_Start;
  logic [7:0] o_Error_Count;

  vga_sync_decoder #(
    .H_ACTIVE (H_ACT),
    .H_FPORCH (H_FP),
    .H_PULSE  (H_PW),
    .H_MAX    (H_MX),
    .V_ACTIVE (V_ACT),
    .V_FPORCH (V_FP),
    .V_PULSE  (V_PW),
    .V_MAX    (V_MX)
  ) dut (
    .i_Clk         (clk),
    .i_Reset       (rst),
    .i_VGA_HSync   (hs),
    .i_VGA_VSync   (vs),
    .i_VGA_Color   (color),
    .o_Locked      (o_Locked),
    .o_Column      (o_Column),
    .o_Row         (o_Row),
    .o_Pixel_Valid (o_Pixel_Valid),
    .o_Color       (o_Color),
    .o_Frame_Start (o_Frame_Start),
    .o_Error_Count (o_Error_Count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int gx = 0, gy = 0, pw = H_PW;
  int hold = 0;
  bit short_once = 0, short_all = 0;
  int cyc = 0, vf_cnt = 0, last_vf = 0;
  int lock_edge = -1;
  bit lock_prev = 0;
  int mon_bad = 0, fs_cnt = 0, valid_cnt = 0;
  int hx[8];
  int hy[8];
  int base;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One pixel of source timing; outputs checked against pixel n-3.
  task automatic step();
    bit is_vf;
    int ex, ey;
    logic ev;
    logic [8:0] ec;
    @(negedge clk);
    if (gx == HS) begin
      pw = (short_all || short_once) ? H_PW - 1 : H_PW;
      short_once = 0;
    end
    hs = !(gx >= HS && gx < HS + pw);
    if (hold > 0) begin
      hs = 1'b1;
      hold--;
    end
    vs = !(gy >= VS && gy < VS + V_PW);
    color = 9'(gx);
    is_vf = (gx == 0 && gy == VS);
    hx[(cyc + 1) % 8] = gx;
    hy[(cyc + 1) % 8] = gy;
    gx++;
    if (gx == H_MX) begin
      gx = 0;
      gy = (gy + 1) % V_MX;
    end
    @(posedge clk);
    cyc++;
    if (is_vf) begin
      vf_cnt++;
      last_vf = cyc;
    end
    #1;
    ex = hx[(cyc + 5) % 8];
    ey = hy[(cyc + 5) % 8];
    ev = o_Locked && ex < H_ACT && ey < V_ACT;
    ec = ev ? 9'(ex) : 9'd0;
    if (o_Pixel_Valid !== ev || o_Color !== ec) mon_bad++;
    if (o_Frame_Start !== (o_Locked && ex == 0 && ey == 0)) mon_bad++;
    if (o_Locked && (int'(o_Column) != ex || int'(o_Row) != ey))
      mon_bad++;
    if (o_Frame_Start) fs_cnt++;
    if (o_Pixel_Valid) valid_cnt++;
    if (o_Locked && !lock_prev) lock_edge = cyc;
    lock_prev = o_Locked;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to_vf(input int n);
    int target;
    target = vf_cnt + n;
    for (int i = 0; i < n * FRAME + 200 && vf_cnt < target; i++)
      step();
    check("vf_wait", vf_cnt, target);
  endtask

  task automatic goto_pix(input int x, input int y);
    for (int i = 0; i < 2 * FRAME && !(gx == x && gy == y); i++)
      step();
    check("goto_x", gx, x);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_locked", o_Locked, 0);
    check("rst_col", o_Column, 0);
    check("rst_err", o_Error_Count, 0);
    check("rst_color", o_Color, 0);
    rst = 1'b0;

    // Acquire from clean timing
    run_to_vf(1);
    steps(4);
    check("acq_unlocked", o_Locked, 0);
    run_to_vf(1);
    steps(5);
    check("lock_latency", lock_edge - last_vf, 3);
    check("lock_err", o_Error_Count, 0);
    check("locked", o_Locked, 1);

    fs_cnt = 0;
    valid_cnt = 0;
    steps(2 * FRAME);
    check("frame_starts", fs_cnt, 2);
    check("valid_pixels", valid_cnt, 2 * H_ACT * V_ACT);
    check("monitor_a", mon_bad, 0);

    // Short HSync pulse while locked
    short_once = 1;
    steps(20);
    check("short_unlock", o_Locked, 0);
    check("short_err", o_Error_Count, 1);
    run_to_vf(1);
    steps(4);
    check("short_acq", o_Locked, 0);
    run_to_vf(1);
    steps(4);
    check("short_relock", o_Locked, 1);
    check("short_err2", o_Error_Count, 1);

    // HSync held high past the timeout
    goto_pix(0, 1);
    base = o_Error_Count;
    hold = 3 * H_MX;
    steps(3 * H_MX + 16);
    valid_cnt = 0;
    check("tmo_unlock", o_Locked, 0);
    check("tmo_err", o_Error_Count, base + 1);
    run_to_vf(1);
    check("tmo_no_valid", valid_cnt, 0);
    run_to_vf(1);
    steps(4);
    check("tmo_relock", o_Locked, 1);
    check("tmo_err2", o_Error_Count, base + 1);

    // Asynchronous reset mid-line
    goto_pix(4, 2);
    steps(4);
    check("pre_rst_valid", o_Pixel_Valid, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_locked", o_Locked, 0);
    check("arst_col", o_Column, 0);
    check("arst_row", o_Row, 0);
    check("arst_valid", o_Pixel_Valid, 0);
    check("arst_color", o_Color, 0);
    check("arst_fs", o_Frame_Start, 0);
    check("arst_err", o_Error_Count, 0);
    steps(3);
    rst = 1'b0;
    run_to_vf(1);
    steps(4);
    check("arst_acq", o_Locked, 0);
    run_to_vf(1);
    steps(4);
    check("arst_relock", o_Locked, 1);
    check("arst_err2", o_Error_Count, 0);

    // Every frame fails in ACQUIRE; count must saturate
    short_all = 1;
    run_to_vf(10);
    steps(20);
    check("sat_11", o_Error_Count, 11);
    run_to_vf(300);
    steps(20);
    check("sat_255", o_Error_Count, 255);
    check("sat_unlocked", o_Locked, 0);
    check("monitor_b", mon_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
